// File: rtl/systolic_pkg.sv
// Shared constants for the systolic feeder and the pe array it drives.
// Holds the feeder FSM encoding and the operand width default.
package systolic_pkg;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// Feeder bus: enable/start control, two word-wide SRAM read ports, array edge drive.
// master = feeder side, slave = environment (SRAMs, array, controller).
interface systolic_feeder_if import systolic_pkg::*; #(
    parameter int N      = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 8
);
    logic                  en;
    logic                  start;
    logic                  a_rd_en;
    logic [ADDR_W-1:0]     a_addr;
    logic [N*DATA_W-1:0]   a_rdata;
    logic                  w_rd_en;
    logic [ADDR_W-1:0]     w_addr;
    logic [N*DATA_W-1:0]   w_rdata;
    logic [N*DATA_W-1:0]   act_out;
    logic [N*DATA_W-1:0]   wgt_out;
    logic                  pe_en;
    logic                  pe_clr;
    logic                  busy;
    logic                  done;

    modport master (
        input  en, start, a_rdata, w_rdata,
        output a_rd_en, a_addr, w_rd_en, w_addr, act_out, wgt_out,
               pe_en, pe_clr, busy, done
    );

    modport slave (
        output en, start, a_rdata, w_rdata,
        input  a_rd_en, a_addr, w_rd_en, w_addr, act_out, wgt_out,
               pe_en, pe_clr, busy, done
    );
endinterface

// File: rtl/skew_line.sv
// Zero-reset register chain of DEPTH stages; latency DEPTH cycles.
// Whole chain freezes while en is low.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// Reads K activation/weight words and streams them diagonally skewed into an NxN array;
// done K+2N cycles after start. en low stalls everything and masks the read/PE strobes.
module systolic_feeder import systolic_pkg::*; #(
    parameter int N      = 4,
    parameter int K      = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    systolic_feeder_if.master bus
);
    localparam int CW = $clog2(K + 2*N + 2);
    // cnt tracks (cycle - 1) from start, so it equals the read address during FETCH
    localparam logic [CW-1:0] FETCH_LAST = CW'(K - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(K + 2*N - 2);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            rd_vld;
    logic [N*DATA_W-1:0] act_q, wgt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rd_vld <= 1'b0;
        end else if (bus.en) begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rd_vld <= (state == ST_FETCH);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_FETCH;
                    cnt_nxt   = '0;
                end
            end
            ST_FETCH: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == FETCH_LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == DRAIN_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.a_rd_en = bus.en && (state == ST_FETCH);
    assign bus.w_rd_en = bus.en && (state == ST_FETCH);
    assign bus.a_addr  = (state == ST_FETCH) ? ADDR_W'(cnt) : '0;
    assign bus.w_addr  = (state == ST_FETCH) ? ADDR_W'(cnt) : '0;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.pe_clr  = (state != ST_IDLE) && (cnt == CW'(1));
    assign bus.pe_en   = bus.en && (state != ST_IDLE) && (cnt >= CW'(2));
    assign bus.act_out = act_q;
    assign bus.wgt_out = wgt_q;

    // lane i delayed i+1 cycles after its first stage sees valid read data
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i + 1), .W(DATA_W)) u_act (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (bus.en),
            .d    (rd_vld ? bus.a_rdata[i*DATA_W +: DATA_W] : {DATA_W{1'b0}}),
            .q    (act_q[i*DATA_W +: DATA_W])
        );
        skew_line #(.DEPTH(i + 1), .W(DATA_W)) u_wgt (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (bus.en),
            .d    (rd_vld ? bus.w_rdata[i*DATA_W +: DATA_W] : {DATA_W{1'b0}}),
            .q    (wgt_q[i*DATA_W +: DATA_W])
        );
    end
endmodule
